// File: rtl/maxmin_pkg.sv
// rtl/maxmin_pkg.sv - shared types and constants for the max/min frame transmitter
package maxmin_pkg;

    localparam int BYTE_W        = 8;
    localparam int FRAME_LEN_DEF = 15;

    localparam logic [BYTE_W-1:0] MAX_INIT = 8'h00;
    localparam logic [BYTE_W-1:0] MIN_INIT = 8'hFF;

    typedef enum logic [1:0] {
        FILL,
        SEND,
        WAIT,
        REPORT
    } state_t;

endpackage

// File: rtl/maxmin_frame_tx_if.sv
// rtl/maxmin_frame_tx_if.sv - loader, consumer and status signals of the frame transmitter
interface maxmin_frame_tx_if;
    import maxmin_pkg::*;

    logic              ld_valid;
    logic [BYTE_W-1:0] ld_data;
    logic              ld_ready;
    logic              tx_valid;
    logic [BYTE_W-1:0] tx_num;
    logic              rsp_valid;
    logic [BYTE_W-1:0] rsp_max;
    logic [BYTE_W-1:0] rsp_min;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [BYTE_W-1:0] exp_max;
    logic [BYTE_W-1:0] exp_min;

    modport master (
        output ld_valid, ld_data, rsp_valid, rsp_max, rsp_min,
        input  ld_ready, tx_valid, tx_num, done, pass, timeout, exp_max, exp_min
    );

    modport slave (
        input  ld_valid, ld_data, rsp_valid, rsp_max, rsp_min,
        output ld_ready, tx_valid, tx_num, done, pass, timeout, exp_max, exp_min
    );

endinterface

// File: rtl/maxmin_track.sv
// rtl/maxmin_track.sv - running max/min tracker with seed/update/hold control
module maxmin_track import maxmin_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed,
    input  logic              update,
    input  logic [BYTE_W-1:0] data,
    output logic [BYTE_W-1:0] exp_max,
    output logic [BYTE_W-1:0] exp_min
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_max <= MAX_INIT;
            exp_min <= MIN_INIT;
        end else if (seed) begin
            exp_max <= data;
            exp_min <= data;
        end else if (update) begin
            if (data > exp_max) exp_max <= data;
            if (data < exp_min) exp_min <= data;
        end
    end

endmodule

// File: rtl/maxmin_frame_tx.sv
// rtl/maxmin_frame_tx.sv - buffers one frame, sends it gap-free, checks the max/min response
module maxmin_frame_tx import maxmin_pkg::*; #(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    maxmin_frame_tx_if.slave   bus
);

    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  FRAME_END = CNT_W'(FRAME_LEN);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wr_cnt, rd_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BYTE_W-1:0]  frame_buf [FRAME_LEN];
    logic [BYTE_W-1:0]  trk_max, trk_min;
    logic               accept, last_accept, send_end, rsp_hit, wait_expired;

    assign accept       = bus.ld_valid && (state == FILL);
    assign last_accept  = accept && (wr_cnt == LAST_IDX);
    assign send_end     = (state == SEND) && (rd_cnt == FRAME_END);
    assign rsp_hit      = (state == WAIT) && bus.rsp_valid;
    assign wait_expired = (state == WAIT) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (last_accept) state_nxt = SEND;
            SEND:    if (send_end) state_nxt = WAIT;
            WAIT:    if (rsp_hit || wait_expired) state_nxt = REPORT;
            REPORT:  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // tx_valid and done decode straight from the state register, so reset drops them at once
    always_comb begin
        bus.ld_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.done     = 1'b0;
        case (state)
            FILL:    bus.ld_ready = 1'b1;
            SEND:    bus.tx_valid = 1'b1;
            REPORT:  bus.done     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) frame_buf[wr_cnt] <= bus.ld_data;
    end

    // the first byte is preloaded on the last accept so SEND starts with no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            wait_cnt    <= '0;
            bus.tx_num  <= '0;
            bus.pass    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            if (accept) wr_cnt <= last_accept ? '0 : wr_cnt + 1'b1;
            if (last_accept) begin
                rd_cnt     <= CNT_W'(1);
                bus.tx_num <= (FRAME_LEN == 1) ? bus.ld_data : frame_buf[0];
            end else if ((state == SEND) && !send_end) begin
                rd_cnt     <= rd_cnt + 1'b1;
                bus.tx_num <= frame_buf[rd_cnt];
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (rsp_hit) begin
                bus.pass    <= (bus.rsp_max == trk_max) && (bus.rsp_min == trk_min);
                bus.timeout <= 1'b0;
            end else if (wait_expired) begin
                bus.pass    <= 1'b0;
                bus.timeout <= 1'b1;
            end
        end
    end

    maxmin_track u_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (accept && (wr_cnt == '0)),
        .update  (accept),
        .data    (bus.ld_data),
        .exp_max (trk_max),
        .exp_min (trk_min)
    );

    assign bus.exp_max = trk_max;
    assign bus.exp_min = trk_min;

endmodule

// File: tb/tb_maxmin_frame_tx.sv
// tb/tb_maxmin_frame_tx.sv - directed bench for maxmin_frame_tx with hand-computed frames
module tb_maxmin_frame_tx;
    import maxmin_pkg::*;

    localparam int FL = 15;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    maxmin_frame_tx_if bus ();

    maxmin_frame_tx #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [7:0] frame [FL];
    bit spurious = 1'b0;

    always @(negedge clk) if (rst_n === 1'b1 && bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < FL; k++) frame[k] = 8'(10 * (k + 1));
    endtask

    task automatic set_mixed();
        logic [7:0] v [FL];
        v = '{8'd5, 8'd255, 8'd17, 8'd0, 8'd99, 8'd128, 8'd3, 8'd200,
              8'd64, 8'd1, 8'd254, 8'd33, 8'd77, 8'd250, 8'd9};
        for (int k = 0; k < FL; k++) frame[k] = v[k];
    endtask

    task automatic load(input bit gaps);
        for (int k = 0; k < FL; k++) begin
            if (gaps && (k % 3 == 2)) begin
                @(negedge clk);
                bus.ld_valid = 1'b0;
                if (spurious) bus.rsp_valid = 1'b1;
            end
            @(negedge clk);
            bus.ld_valid = 1'b1;
            bus.ld_data  = frame[k];
            if (spurious) begin
                bus.rsp_valid = k[0];
                bus.rsp_max   = 8'd0;
                bus.rsp_min   = 8'd0;
            end
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'd0;
        chk("ld_ready_in_send", bus.ld_ready, 1'b0);
    endtask

    task automatic send_check();
        int w = 0;
        while (bus.tx_valid !== 1'b1 && w < 4) begin
            @(negedge clk);
            w++;
        end
        chk("tx_start_latency", w, 0);
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("tx_valid[%0d]", i), bus.tx_valid, 1'b1);
            chk($sformatf("tx_num[%0d]", i), bus.tx_num, frame[i]);
            if (spurious) bus.rsp_valid = i[0];
            @(negedge clk);
        end
        bus.rsp_valid = 1'b0;
        chk("tx_gap_after_frame", bus.tx_valid, 1'b0);
    endtask

    task automatic respond(input bit give, input logic [7:0] mx, input logic [7:0] mn,
                           input bit want_pass, input logic [7:0] emx, input logic [7:0] emn);
        chk("no_early_done", done_cnt, exp_done);
        if (give) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_max   = mx;
            bus.rsp_min   = mn;
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            chk("done_pulse", bus.done, 1'b1);
        end else begin
            int n = 0;
            while (bus.done !== 1'b1 && n < TO + 10) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", n, TO);
        end
        chk("pass", bus.pass, want_pass);
        chk("timeout", bus.timeout, !give);
        chk("exp_max", bus.exp_max, emx);
        chk("exp_min", bus.exp_min, emn);
        exp_done++;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
        chk("ld_ready_after", bus.ld_ready, 1'b1);
        chk("pass_held", bus.pass, want_pass);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 8'd0;
        bus.rsp_valid = 1'b0;
        bus.rsp_max   = 8'd0;
        bus.rsp_min   = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_ld_ready", bus.ld_ready, 1'b1);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_num", bus.tx_num, 8'd0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_pass", bus.pass, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        chk("rst_exp_max", bus.exp_max, MAX_INIT);
        chk("rst_exp_min", bus.exp_min, MIN_INIT);
        @(negedge clk);
        rst_n = 1'b1;

        set_ramp();
        load(1'b0);
        send_check();
        respond(1'b1, 8'd150, 8'd10, 1'b1, 8'd150, 8'd10);

        set_mixed();
        load(1'b1);
        chk("gap_exp_max", bus.exp_max, 8'd255);
        chk("gap_exp_min", bus.exp_min, 8'd0);
        send_check();
        respond(1'b1, 8'd255, 8'd0, 1'b1, 8'd255, 8'd0);

        load(1'b1);
        send_check();
        respond(1'b1, 8'd254, 8'd0, 1'b0, 8'd255, 8'd0);

        set_ramp();
        load(1'b0);
        send_check();
        respond(1'b0, 8'd0, 8'd0, 1'b0, 8'd150, 8'd10);

        set_mixed();
        load(1'b0);
        repeat (6) @(negedge clk);
        chk("rst7_tx_valid_before", bus.tx_valid, 1'b1);
        chk("rst7_tx_num_before", bus.tx_num, frame[6]);
        rst_n = 1'b0;
        #1;
        chk("rst7_tx_valid_async", bus.tx_valid, 1'b0);
        chk("rst7_ld_ready_async", bus.ld_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst7_ld_ready", bus.ld_ready, 1'b1);
        chk("rst7_exp_max", bus.exp_max, MAX_INIT);
        chk("rst7_exp_min", bus.exp_min, MIN_INIT);

        for (int k = 0; k < FL; k++) frame[k] = 8'd77;
        load(1'b0);
        send_check();
        respond(1'b1, 8'd77, 8'd77, 1'b1, 8'd77, 8'd77);

        set_ramp();
        spurious = 1'b1;
        load(1'b1);
        send_check();
        spurious = 1'b0;
        respond(1'b1, 8'd150, 8'd10, 1'b1, 8'd150, 8'd10);

        @(negedge clk);
        chk("done_total", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
